// File: rtl/pc_fetch_pkg.sv
// Shared widths, hold codes, NOP encoding and FSM encodings for the PC/fetch stage.
package pc_fetch_pkg;

    localparam int ADDR_BUS_WIDTH = 64;
    localparam int INST_BUS_WIDTH = 32;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [INST_BUS_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    localparam logic PC_FETCH_S_REQ  = 1'b0;
    localparam logic PC_FETCH_S_WAIT = 1'b1;

    typedef enum logic {
        S_REQ  = PC_FETCH_S_REQ,
        S_WAIT = PC_FETCH_S_WAIT
    } fetch_state_e;

    // Any code at or above HOLD_PC stalls the fetch stage.
    function automatic logic hold_active(input logic [2:0] code);
        return code >= HOLD_PC;
    endfunction

endpackage

// File: rtl/pc_fetch_buf.sv
// One-entry instruction+address holding buffer used while the ID stage is held.
module pc_fetch_buf
    import pc_fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [INST_BUS_WIDTH-1:0] wr_inst,
    input  logic [ADDR_BUS_WIDTH-1:0] wr_addr,
    input  logic                      rd_en,
    input  logic                      flush,
    output logic                      full_o,
    output logic [INST_BUS_WIDTH-1:0] rd_inst_o,
    output logic [ADDR_BUS_WIDTH-1:0] rd_addr_o
);

    logic                      valid_q, valid_d;
    logic [INST_BUS_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;

    // Flush wins over write, write wins over read.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (wr_en) begin
            valid_d = 1'b1;
            inst_d  = wr_inst;
            addr_d  = wr_addr;
        end else if (rd_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= INST_NOP;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
        end
    end

    assign full_o    = valid_q;
    assign rd_inst_o = inst_q;
    assign rd_addr_o = addr_q;

endmodule

// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction fetch feeding the ID stage.
// Optional misaligned-jump reporting is enabled by defining PC_MISALIGN_CHK_EN.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [ADDR_BUS_WIDTH-1:0] RESET_PC = 64'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jump_en_i,
    input  logic [ADDR_BUS_WIDTH-1:0] jump_addr_i,
    input  logic [2:0]                pipe_hold_en_i,
    output logic                      ifetch_req_o,
    output logic [ADDR_BUS_WIDTH-1:0] ifetch_addr_o,
    input  logic                      ifetch_gnt_i,
    input  logic                      ifetch_rvalid_i,
    input  logic [INST_BUS_WIDTH-1:0] ifetch_rdata_i,
    output logic                      inst_valid_o,
    output logic [INST_BUS_WIDTH-1:0] inst_o,
    output logic [ADDR_BUS_WIDTH-1:0] inst_addr_o,
`ifdef PC_MISALIGN_CHK_EN
    output logic                      inst_misalign_o,
`endif
    output fetch_state_e              dbg_state_o
);

    // Bus handshake: a request is accepted in the cycle where req and gnt are both 1;
    // the address stays on the bus unchanged until then. Exactly one rvalid follows
    // each accepted request, in a later cycle, carrying the instruction word.

    fetch_state_e              state_q, state_d;
    logic [ADDR_BUS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_BUS_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic                      kill_q, kill_d;
    logic                      inst_valid_q, inst_valid_d;
    logic [INST_BUS_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_BUS_WIDTH-1:0] inst_addr_q, inst_addr_d;

    logic                      hold;
    logic                      halted;
    logic                      jump_misalign;
    logic [ADDR_BUS_WIDTH-1:0] jump_tgt;
    logic                      fetch_go;
    logic                      rsp;
    logic                      live_rsp;

    logic                      buf_wr, buf_rd, buf_flush, buf_full;
    logic [INST_BUS_WIDTH-1:0] buf_inst;
    logic [ADDR_BUS_WIDTH-1:0] buf_addr;

`ifdef PC_MISALIGN_CHK_EN
    logic halted_q, halted_d;
    logic misalign_q, misalign_d;

    assign jump_tgt        = jump_addr_i;
    assign jump_misalign   = jump_en_i & (jump_addr_i[1:0] != 2'b00);
    assign halted          = halted_q;
    assign inst_misalign_o = misalign_q;
`else
    assign jump_tgt      = jump_addr_i & ~64'h3;
    assign jump_misalign = 1'b0;
    assign halted        = 1'b0;
`endif

    assign hold          = hold_active(pipe_hold_en_i);
    assign ifetch_req_o  = !rst && (state_q == S_REQ) && !jump_en_i && !hold
                           && !buf_full && !halted;
    assign ifetch_addr_o = pc_q;
    assign fetch_go      = ifetch_req_o & ifetch_gnt_i;
    assign rsp           = (state_q == S_WAIT) & ifetch_rvalid_i;
    assign live_rsp      = rsp & !kill_q & !jump_en_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        buf_wr       = 1'b0;
        buf_rd       = 1'b0;
        buf_flush    = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
        halted_d     = halted_q;
        misalign_d   = misalign_q;
`endif

        case (state_q)
            S_REQ: begin
                if (jump_en_i) begin
                    pc_d = jump_tgt;
                end else if (fetch_go) begin
                    pc_d         = pc_q + 64'd4;
                    fetch_addr_d = pc_q;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ifetch_rvalid_i) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                end
                // A response landing with the jump is dropped here, so only arm kill otherwise.
                if (jump_en_i) begin
                    pc_d   = jump_tgt;
                    kill_d = !ifetch_rvalid_i;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (jump_en_i) begin
            inst_valid_d = 1'b0;
            inst_d       = INST_NOP;
            buf_flush    = 1'b1;
`ifdef PC_MISALIGN_CHK_EN
            halted_d   = jump_misalign;
            misalign_d = jump_misalign;
            if (jump_misalign) begin
                inst_valid_d = 1'b1;
                inst_addr_d  = jump_tgt;
            end
`endif
        end else if (hold) begin
            if (live_rsp) begin
                buf_wr = 1'b1;
            end
        end else begin
`ifdef PC_MISALIGN_CHK_EN
            misalign_d = 1'b0;
`endif
            if (buf_full) begin
                inst_valid_d = 1'b1;
                inst_d       = buf_inst;
                inst_addr_d  = buf_addr;
                buf_rd       = 1'b1;
            end else if (live_rsp) begin
                inst_valid_d = 1'b1;
                inst_d       = ifetch_rdata_i;
                inst_addr_d  = fetch_addr_q;
            end else begin
                inst_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            fetch_addr_q <= '0;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= INST_NOP;
            inst_addr_q  <= '0;
`ifdef PC_MISALIGN_CHK_EN
            halted_q     <= 1'b0;
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
`ifdef PC_MISALIGN_CHK_EN
            halted_q     <= halted_d;
            misalign_q   <= misalign_d;
`endif
        end
    end

    pc_fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (buf_wr),
        .wr_inst   (ifetch_rdata_i),
        .wr_addr   (fetch_addr_q),
        .rd_en     (buf_rd),
        .flush     (buf_flush),
        .full_o    (buf_full),
        .rd_inst_o (buf_inst),
        .rd_addr_o (buf_addr)
    );

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;
    assign dbg_state_o  = state_q;

endmodule
